// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if
//   Bundles the decode-side inputs and execute-side outputs of the ID/EX
//   pipeline register into one interface.
//   master : drives flush/freeze and the *_in fields, observes the outputs
//   slave  : the pipeline register itself
//   Parameters: WIDTH (data/PC width), CNT_W (bubble counter width)
interface id_ex_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             flush;
  logic             freeze;
  logic             valid_in;
  logic [8:0]       ctrl_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] val_rn_in;
  logic [WIDTH-1:0] val_rm_in;
  logic             imm_in;
  logic [11:0]      shift_operand_in;
  logic [23:0]      signed_imm_24_in;
  logic [3:0]       dest_in;
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;
  logic             status_c_in;

  logic [3:0]       exe_cmd;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             wb_en;
  logic             b;
  logic             s;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] val_rn;
  logic [WIDTH-1:0] val_rm;
  logic             imm;
  logic [11:0]      shift_operand;
  logic [23:0]      signed_imm_24;
  logic [3:0]       dest;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             carry;
  logic             valid;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output flush, freeze, valid_in, ctrl_in, pc_in, val_rn_in, val_rm_in,
           imm_in, shift_operand_in, signed_imm_24_in, dest_in, src1_in,
           src2_in, status_c_in,
    input  exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, src1, src2, carry,
           valid, bubble_cnt
  );

  modport slave (
    input  flush, freeze, valid_in, ctrl_in, pc_in, val_rn_in, val_rm_in,
           imm_in, shift_operand_in, signed_imm_24_in, dest_in, src1_in,
           src2_in, status_c_in,
    output exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, src1, src2, carry,
           valid, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//   Pipeline register between decode and execute. Captures the control
//   word, operands, immediates and register tags every cycle, holds them on
//   freeze, and replaces them with a bubble on flush. A saturating counter
//   records how many bubbles flush has inserted.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset, clears every output
//     bus  - id_ex_stage_reg_if slave modport (inputs *_in, flush, freeze;
//            outputs are all direct flop outputs)
module id_ex_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  id_ex_stage_reg_if.slave bus
);

  logic [8:0]       r_ctrl;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_valRn;
  logic [WIDTH-1:0] r_valRm;
  logic             r_imm;
  logic [11:0]      r_shiftOperand;
  logic [23:0]      r_signedImm24;
  logic [3:0]       r_dest;
  logic [3:0]       r_src1;
  logic [3:0]       r_src2;
  logic             r_carry;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubbleCnt;

  // Flush outranks freeze so a wrong-path instruction can never be held
  // into execute. An invalid decode slot loads a zero control word so it
  // has no side effects downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl         <= '0;
      r_pc           <= '0;
      r_valRn        <= '0;
      r_valRm        <= '0;
      r_imm          <= 1'b0;
      r_shiftOperand <= '0;
      r_signedImm24  <= '0;
      r_dest         <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_carry        <= 1'b0;
      r_valid        <= 1'b0;
      r_bubbleCnt    <= '0;
    end else if (bus.flush) begin
      r_ctrl         <= '0;
      r_pc           <= '0;
      r_valRn        <= '0;
      r_valRm        <= '0;
      r_imm          <= 1'b0;
      r_shiftOperand <= '0;
      r_signedImm24  <= '0;
      r_dest         <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_carry        <= 1'b0;
      r_valid        <= 1'b0;
      // Saturate instead of wrapping at all-ones.
      if (r_bubbleCnt != {CNT_W{1'b1}}) begin
        r_bubbleCnt <= r_bubbleCnt + 1'b1;
      end
    end else if (!bus.freeze) begin
      r_ctrl         <= bus.valid_in ? bus.ctrl_in : 9'd0;
      r_pc           <= bus.pc_in;
      r_valRn        <= bus.val_rn_in;
      r_valRm        <= bus.val_rm_in;
      r_imm          <= bus.imm_in;
      r_shiftOperand <= bus.shift_operand_in;
      r_signedImm24  <= bus.signed_imm_24_in;
      r_dest         <= bus.dest_in;
      r_src1         <= bus.src1_in;
      r_src2         <= bus.src2_in;
      r_carry        <= bus.status_c_in;
      r_valid        <= bus.valid_in;
    end
  end

  // Control outputs are slices of the registered control word.
  assign bus.exe_cmd       = r_ctrl[8:5];
  assign bus.mem_r_en      = r_ctrl[4];
  assign bus.mem_w_en      = r_ctrl[3];
  assign bus.wb_en         = r_ctrl[2];
  assign bus.b             = r_ctrl[1];
  assign bus.s             = r_ctrl[0];
  assign bus.pc            = r_pc;
  assign bus.val_rn        = r_valRn;
  assign bus.val_rm        = r_valRm;
  assign bus.imm           = r_imm;
  assign bus.shift_operand = r_shiftOperand;
  assign bus.signed_imm_24 = r_signedImm24;
  assign bus.dest          = r_dest;
  assign bus.src1          = r_src1;
  assign bus.src2          = r_src2;
  assign bus.carry         = r_carry;
  assign bus.valid         = r_valid;
  assign bus.bubble_cnt    = r_bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg
//   Self-checking bench for id_ex_stage_reg: directed scenarios followed by
//   randomized stimulus, all compared against a behavioural model.
module tb_id_ex_stage_reg;
  localparam int WIDTH  = 32;
  localparam int CNT_W  = 8;
  localparam int CNTMAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  id_ex_stage_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  id_ex_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pipeline contents as seen by the execute stage.
  typedef struct {
    logic [8:0]       ctrl;
    logic [WIDTH-1:0] pc, rn, rm;
    logic             imm;
    logic [11:0]      sh;
    logic [23:0]      off;
    logic [3:0]       dest, s1, s2;
    logic             carry, valid;
    int               cnt;
  } modelT;

  modelT model;

  function automatic modelT emptyEntry(int cnt);
    modelT e;
    e.ctrl = '0; e.pc = '0; e.rn = '0; e.rm = '0; e.imm = 1'b0;
    e.sh = '0; e.off = '0; e.dest = '0; e.s1 = '0; e.s2 = '0;
    e.carry = 1'b0; e.valid = 1'b0; e.cnt = cnt;
    return e;
  endfunction

  // Behaviour at one clock edge, written from the priority rules.
  task automatic modelEdge();
    if (bus.flush) begin
      model = emptyEntry((model.cnt < CNTMAX) ? model.cnt + 1 : CNTMAX);
    end else if (!bus.freeze) begin
      model.ctrl  = bus.valid_in ? bus.ctrl_in : 9'd0;
      model.pc    = bus.pc_in;
      model.rn    = bus.val_rn_in;
      model.rm    = bus.val_rm_in;
      model.imm   = bus.imm_in;
      model.sh    = bus.shift_operand_in;
      model.off   = bus.signed_imm_24_in;
      model.dest  = bus.dest_in;
      model.s1    = bus.src1_in;
      model.s2    = bus.src2_in;
      model.carry = bus.status_c_in;
      model.valid = bus.valid_in;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag,
               observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".exe_cmd"}, 64'(bus.exe_cmd), 64'(model.ctrl[8:5]));
    checkOutput({tag, ".mem_r_en"}, 64'(bus.mem_r_en), 64'(model.ctrl[4]));
    checkOutput({tag, ".mem_w_en"}, 64'(bus.mem_w_en), 64'(model.ctrl[3]));
    checkOutput({tag, ".wb_en"}, 64'(bus.wb_en), 64'(model.ctrl[2]));
    checkOutput({tag, ".b"}, 64'(bus.b), 64'(model.ctrl[1]));
    checkOutput({tag, ".s"}, 64'(bus.s), 64'(model.ctrl[0]));
    checkOutput({tag, ".pc"}, 64'(bus.pc), 64'(model.pc));
    checkOutput({tag, ".val_rn"}, 64'(bus.val_rn), 64'(model.rn));
    checkOutput({tag, ".val_rm"}, 64'(bus.val_rm), 64'(model.rm));
    checkOutput({tag, ".imm"}, 64'(bus.imm), 64'(model.imm));
    checkOutput({tag, ".shift"}, 64'(bus.shift_operand), 64'(model.sh));
    checkOutput({tag, ".imm24"}, 64'(bus.signed_imm_24), 64'(model.off));
    checkOutput({tag, ".dest"}, 64'(bus.dest), 64'(model.dest));
    checkOutput({tag, ".src1"}, 64'(bus.src1), 64'(model.s1));
    checkOutput({tag, ".src2"}, 64'(bus.src2), 64'(model.s2));
    checkOutput({tag, ".carry"}, 64'(bus.carry), 64'(model.carry));
    checkOutput({tag, ".valid"}, 64'(bus.valid), 64'(model.valid));
    checkOutput({tag, ".bubble_cnt"}, 64'(bus.bubble_cnt), 64'(model.cnt));
  endtask

  // Drive one set of inputs; fields not named here get random values.
  task automatic applyStimulus(input bit fl, input bit fr, input bit v,
                               input logic [8:0] ctrl,
                               input logic [WIDTH-1:0] rn,
                               input logic [WIDTH-1:0] rm,
                               input logic [3:0] dest);
    bus.flush            = fl;
    bus.freeze           = fr;
    bus.valid_in         = v;
    bus.ctrl_in          = ctrl;
    bus.val_rn_in        = rn;
    bus.val_rm_in        = rm;
    bus.dest_in          = dest;
    bus.pc_in            = $urandom;
    bus.imm_in           = 1'($urandom);
    bus.shift_operand_in = 12'($urandom);
    bus.signed_imm_24_in = 24'($urandom);
    bus.src1_in          = 4'($urandom);
    bus.src2_in          = 4'($urandom);
    bus.status_c_in      = 1'($urandom);
  endtask

  // One clock edge: update the model from the inputs present at the edge,
  // then sample the outputs 1 time unit later.
  task automatic stepCycle(input string tag);
    @(posedge clk);
    if (!rst) modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic asyncReset(input string tag);
    rst = 1'b1;
    #1;
    model = emptyEntry(0);
    checkAll(tag);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [8:0] CTRL_ADD = 9'b0010_0010_1;
  localparam logic [8:0] CTRL_STR = 9'b0010_0100_0;
  localparam logic [8:0] CTRL_LDR = 9'b0010_1010_0;
  localparam logic [8:0] CTRL_BR  = 9'b0000_0011_0;

  initial begin
    checkCount = 0;
    passCount  = 0;
    model      = emptyEntry(0);
    rst        = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, '0, '0, '0);
    #12;
    rst = 1'b0;
    checkAll("init");

    // Reset asserted between edges with nonzero inputs and a nonzero counter.
    applyStimulus(1'b1, 1'b0, 1'b1, CTRL_ADD, 32'hDEAD, 32'hBEEF, 4'hF);
    stepCycle("preFlush");
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h1FF, 32'hFFFF_FFFF, 32'h1234, 4'hA);
    stepCycle("preLoad");
    #2;
    asyncReset("asyncRst");

    // Normal load of an ADD with writeback and S.
    applyStimulus(1'b0, 1'b0, 1'b1, CTRL_ADD, 32'd5, 32'd7, 4'd3);
    stepCycle("addLoad");
    checkOutput("addExe", 64'(bus.exe_cmd), 64'h2);
    checkOutput("addWb", 64'(bus.wb_en), 64'h1);
    checkOutput("addS", 64'(bus.s), 64'h1);
    checkOutput("addRn", 64'(bus.val_rn), 64'd5);
    checkOutput("addRm", 64'(bus.val_rm), 64'd7);
    checkOutput("addDest", 64'(bus.dest), 64'd3);
    checkOutput("addValid", 64'(bus.valid), 64'h1);

    // Freeze for 3 cycles while an STR waits at the inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, CTRL_STR, 32'd100 + i, 32'd9, 4'd8);
      stepCycle("freeze");
      checkOutput("frzRn", 64'(bus.val_rn), 64'd5);
      checkOutput("frzWb", 64'(bus.wb_en), 64'h1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, CTRL_STR, 32'd100, 32'd9, 4'd8);
    stepCycle("strLoad");
    checkOutput("strMemW", 64'(bus.mem_w_en), 64'h1);
    checkOutput("strRn", 64'(bus.val_rn), 64'd100);

    // Flush and freeze together: flush wins.
    applyStimulus(1'b1, 1'b1, 1'b1, CTRL_LDR, 32'd11, 32'd12, 4'd4);
    stepCycle("flushFrz");
    checkOutput("ffValid", 64'(bus.valid), 64'h0);
    checkOutput("ffMemR", 64'(bus.mem_r_en), 64'h0);
    checkOutput("ffWb", 64'(bus.wb_en), 64'h0);
    checkOutput("ffCnt", 64'(bus.bubble_cnt), 64'd1);

    // Invalid slot carrying a branch control word.
    applyStimulus(1'b0, 1'b0, 1'b0, CTRL_BR, 32'd1, 32'd2, 4'd6);
    stepCycle("invalid");
    checkOutput("invB", 64'(bus.b), 64'h0);
    checkOutput("invWb", 64'(bus.wb_en), 64'h0);
    checkOutput("invValid", 64'(bus.valid), 64'h0);
    checkOutput("invCnt", 64'(bus.bubble_cnt), 64'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
                    1'($urandom), 9'($urandom), $urandom, $urandom,
                    4'($urandom));
      if ($urandom_range(0, 40) == 0) asyncReset("rndRst");
      stepCycle("rnd");
    end

    // Counter saturation over 260 consecutive flushes.
    asyncReset("satRst");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'b1, 9'($urandom), $urandom,
                    $urandom, 4'($urandom));
      stepCycle("sat");
    end
    checkOutput("satCnt", 64'(bus.bubble_cnt), 64'd255);
    applyStimulus(1'b0, 1'b0, 1'b1, CTRL_ADD, 32'd1, 32'd2, 4'd1);
    stepCycle("postSat");
    checkOutput("postSatCnt", 64'(bus.bubble_cnt), 64'd255);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between the decode stage, where the control unit produces its 9-bit control word, and the execute stage of the ARM pipeline. It captures the decoded control word, operands, immediates and register tags each cycle. It supports stalls (`freeze`) from the hazard unit and bubble insertion (`flush`) on a taken branch. It also keeps a saturating count of inserted bubbles for performance debug.

## Interface
Parameters:
- `WIDTH`, 32, data/PC width
- `CNT_W`, 8, width of bubble counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  replace next captured entry with a bubble
- `freeze`  in  1  hold current contents
- `valid_in`  in  1  decode stage holds a real instruction
- `ctrl_in`  in  9  control word: [8:5] exe cmd, [4] mem_read, [3] mem_write, [2] WB_Enable, [1] B, [0] S
- `pc_in`  in  WIDTH  PC+4 of the instruction
- `val_rn_in`, `val_rm_in`  in  WIDTH  register-file read data
- `imm_in`  in  1  immediate-operand flag
- `shift_operand_in`  in  12  shifter operand field
- `signed_imm_24_in`  in  24  branch offset
- `dest_in`, `src1_in`, `src2_in`  in  4  destination and source register tags
- `status_c_in`  in  1  current carry flag (for ADC/SBC)
- `exe_cmd`  out  4;  `mem_r_en`, `mem_w_en`, `wb_en`, `b`, `s`  out  1 each
- `pc`, `val_rn`, `val_rm`  out  WIDTH
- `imm`  out  1;  `shift_operand`  out  12;  `signed_imm_24`  out  24
- `dest`, `src1`, `src2`  out  4;  `carry`  out  1
- `valid`  out  1  stage holds a real instruction
- `bubble_cnt`  out  CNT_W  number of flush-inserted bubbles, saturating

## Operation
- Each rising edge applies the first matching rule, in this priority order:
  1. `rst`: all outputs go to 0, including `bubble_cnt`. This is asynchronous and takes effect immediately, independent of `clk`.
  2. `flush`: load a bubble. All control outputs, `valid` and `carry` become 0. Data and tag fields become 0. `bubble_cnt` increments.
  3. `freeze`: all registers hold, including `bubble_cnt`.
  4. Otherwise, load all `*_in` values.
     - `valid` takes `valid_in`.
     - If `valid_in` is 0, the control outputs load 0 regardless of `ctrl_in`, so there are no side effects.
- `flush` and `freeze` asserted together: flush wins. A bubble is loaded and the counter increments, because a wrong-path instruction must never reach execute.
- A bubble has `wb_en` = `mem_w_en` = `b` = `s` = 0. Downstream stages must see no architectural effect.
- `bubble_cnt` saturates at 2^CNT_W−1. A further flush leaves it at that value and does not wrap.
- No combinational path from any input to any output. All outputs are flops.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- Freeze may be held for any number of cycles. The outputs stay bit-identical throughout.
- Flush takes effect at the same edge it is sampled. It lasts exactly one bubble per asserted cycle.
- Reset can be asserted mid-stall or mid-flush. Outputs clear asynchronously. On the first edge after deassertion the normal priority rules apply.
- Reset value of every output is 0.

## Test plan
- **Reset:** drive all inputs nonzero and assert `rst` between clock edges. All outputs go to 0 before the next edge and `bubble_cnt` = 0.
- **Normal load:** `valid_in`=1, `ctrl_in`=9'b0010_0010_1 (ADD, wb, S), `val_rn_in`=5, `val_rm_in`=7, `dest_in`=3, then one edge.
  - Outputs show `exe_cmd`=0010, `wb_en`=1, `s`=1, `val_rn`=5, `val_rm`=7, `dest`=3, `valid`=1.
- **Freeze:** load an ADD, then hold `freeze`=1 for 3 cycles while the inputs change to an STR. The outputs keep the ADD values for all 3 cycles. After release, the STR appears with `mem_w_en`=1 one edge later.
- **Flush over freeze:** with a valid LDR presented, assert `flush`=1 and `freeze`=1 together.
  - After the edge: `valid`=0, `mem_r_en`=0, `wb_en`=0, `b`=0, `bubble_cnt`=1.
- **Invalid slot:** `valid_in`=0, `ctrl_in`=9'b0000_0011_0 (branch). After the edge: `b`=0, `wb_en`=0, `valid`=0, and `bubble_cnt` is unchanged.
- **Counter saturation:** with `CNT_W`=8, hold `flush` for 260 cycles. `bubble_cnt` reaches 255 and stays at 255 with no wrap to 0.
